// File: rtl/lane_handshake_responder.sv
// rtl/lane_handshake_responder.sv - far-end 4-lane round-robin 4-phase handshake responder
// All outputs are registered; y is a one-hot of the served lane while in ACK.
module lane_handshake_responder #(
   parameter int LATENCY   = 2,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 I_0_x,
   output logic                 I_0_y,
   input  logic                 I_1_x,
   output logic                 I_1_y,
   input  logic                 I_2_x,
   output logic                 I_2_y,
   input  logic                 I_3_x,
   output logic                 I_3_y,
   output logic                 busy,
   output logic [1:0]           grant,
   output logic [CNT_WIDTH-1:0] done_count,
   output logic                 proto_err
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

   state_t               state, state_nx;
   logic [1:0]           g, g_nx;
   logic [1:0]           ptr, ptr_nx;
   logic [3:0]           cnt, cnt_nx;
   logic [CNT_WIDTH-1:0] done_nx;
   logic                 err_nx;
   logic [3:0]           x;
   logic [3:0]           y_q, y_nx;
   logic                 found;
   logic [1:0]           pick, idx;

   assign x = {I_3_x, I_2_x, I_1_x, I_0_x};

   always_comb begin
      state_nx = state;
      g_nx     = g;
      ptr_nx   = ptr;
      cnt_nx   = cnt;
      done_nx  = done_count;
      err_nx   = proto_err;
      found    = 1'b0;
      pick     = ptr;
      idx      = ptr;

      // Round-robin scan starting at ptr; first requesting lane wins.
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (!found && x[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      case (state)
         IDLE: begin
            if (found) begin
               g_nx = pick;
               if (LATENCY == 0) begin
                  state_nx = ACK;
               end else begin
                  state_nx = WAIT;
                  cnt_nx   = 4'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (!x[g]) begin
               state_nx = IDLE;
               err_nx   = 1'b1;
               ptr_nx   = g + 2'd1;
            end else if (cnt == 4'd0) begin
               state_nx = ACK;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         ACK: begin
            if (!x[g]) begin
               state_nx = IDLE;
               ptr_nx   = g + 2'd1;
               done_nx  = done_count + CNT_WIDTH'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      y_nx = 4'b0000;
      if (state_nx == ACK) begin
         y_nx[g_nx] = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         g          <= 2'd0;
         ptr        <= 2'd0;
         cnt        <= 4'd0;
         done_count <= '0;
         proto_err  <= 1'b0;
         y_q        <= 4'b0000;
         busy       <= 1'b0;
         grant      <= 2'd0;
      end else begin
         state      <= state_nx;
         g          <= g_nx;
         ptr        <= ptr_nx;
         cnt        <= cnt_nx;
         done_count <= done_nx;
         proto_err  <= err_nx;
         y_q        <= y_nx;
         busy       <= (state_nx != IDLE);
         grant      <= (state_nx == IDLE) ? 2'd0 : g_nx;
      end
   end

   assign I_0_y = y_q[0];
   assign I_1_y = y_q[1];
   assign I_2_y = y_q[2];
   assign I_3_y = y_q[3];

endmodule

// File: tb/tb_lane_handshake_responder.sv
// tb/tb_lane_handshake_responder.sv - directed bench for lane_handshake_responder
// Instance a: LATENCY=2, CNT_WIDTH=8. Instance b: LATENCY=0, CNT_WIDTH=2.
module tb_lane_handshake_responder;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [3:0] ax, ay, bx, by;
   logic       abusy, aerr, bbusy, berr;
   logic [1:0] agrant, bgrant;
   logic [7:0] adone;
   logic [1:0] bdone;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 CLK = ~CLK;

   lane_handshake_responder #(.LATENCY(2), .CNT_WIDTH(8)) dut_a (
      .CLK(CLK), .RESET(RESET),
      .I_0_x(ax[0]), .I_0_y(ay[0]),
      .I_1_x(ax[1]), .I_1_y(ay[1]),
      .I_2_x(ax[2]), .I_2_y(ay[2]),
      .I_3_x(ax[3]), .I_3_y(ay[3]),
      .busy(abusy), .grant(agrant), .done_count(adone), .proto_err(aerr)
   );

   lane_handshake_responder #(.LATENCY(0), .CNT_WIDTH(2)) dut_b (
      .CLK(CLK), .RESET(RESET),
      .I_0_x(bx[0]), .I_0_y(by[0]),
      .I_1_x(bx[1]), .I_1_y(by[1]),
      .I_2_x(bx[2]), .I_2_y(by[2]),
      .I_3_x(bx[3]), .I_3_y(by[3]),
      .busy(bbusy), .grant(bgrant), .done_count(bdone), .proto_err(berr)
   );

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      RESET = 1'b1;
      ax    = 4'b0000;
      bx    = 4'b0000;
      tick(2);
      chk("rst_a_y", 32'(ay), 32'h0);
      chk("rst_a_busy", 32'(abusy), 32'h0);
      chk("rst_a_grant", 32'(agrant), 32'h0);
      chk("rst_a_done", 32'(adone), 32'h0);
      chk("rst_a_err", 32'(aerr), 32'h0);
      chk("rst_b_y", 32'(by), 32'h0);
      chk("rst_b_done", 32'(bdone), 32'h0);
      RESET = 1'b0;

      // Single request on lane 2: ack at cycle 3, release at cycle 6.
      ax = 4'b0100;
      tick(2);
      chk("t1_wait_y", 32'(ay), 32'h0);
      chk("t1_wait_busy", 32'(abusy), 32'h1);
      chk("t1_wait_grant", 32'(agrant), 32'h2);
      tick(1);
      chk("t1_ack_y", 32'(ay), 32'h4);
      chk("t1_ack_busy", 32'(abusy), 32'h1);
      chk("t1_ack_grant", 32'(agrant), 32'h2);
      tick(3);
      chk("t1_hold_y", 32'(ay), 32'h4);
      ax = 4'b0000;
      tick(1);
      chk("t1_rel_y", 32'(ay), 32'h0);
      chk("t1_rel_busy", 32'(abusy), 32'h0);
      chk("t1_rel_grant", 32'(agrant), 32'h0);
      chk("t1_rel_done", 32'(adone), 32'h1);

      // All four lanes at once after reset; acks 6 cycles apart in lane order.
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      ax = 4'b1111;
      tick(2);
      for (int k = 0; k < 4; k++) begin
         chk("t2_gap_y", 32'(ay), 32'h0);
         tick(1);
         chk("t2_ack_y", 32'(ay), 32'(1 << k));
         chk("t2_ack_grant", 32'(agrant), 32'(k));
         tick(2);
         chk("t2_hold_y", 32'(ay), 32'(1 << k));
         ax[k] = 1'b0;
         tick(1);
         chk("t2_rel_y", 32'(ay), 32'h0);
         chk("t2_rel_done", 32'(adone), 32'(k + 1));
         tick(2);
      end
      chk("t2_end_busy", 32'(abusy), 32'h0);
      chk("t2_end_done", 32'(adone), 32'h4);

      // Lane 0 completes (ptr=1), then lanes 0 and 3 together: lane 3 first.
      ax = 4'b0001;
      tick(3);
      chk("t3_l0_y", 32'(ay), 32'h1);
      ax = 4'b0000;
      tick(1);
      chk("t3_l0_done", 32'(adone), 32'h5);
      ax = 4'b1001;
      tick(3);
      chk("t3_first_y", 32'(ay), 32'h8);
      chk("t3_first_grant", 32'(agrant), 32'h3);
      ax = 4'b0001;
      tick(1);
      chk("t3_gap_y", 32'(ay), 32'h0);
      tick(2);
      chk("t3_gap2_y", 32'(ay), 32'h0);
      tick(1);
      chk("t3_second_y", 32'(ay), 32'h1);
      chk("t3_second_grant", 32'(agrant), 32'h0);
      ax = 4'b0000;
      tick(1);
      chk("t3_done", 32'(adone), 32'h7);

      // Lane 1 drops its request during WAIT: abort with sticky error.
      ax = 4'b0010;
      tick(1);
      chk("t4_wait_grant", 32'(agrant), 32'h1);
      ax = 4'b0000;
      tick(1);
      chk("t4_err", 32'(aerr), 32'h1);
      chk("t4_busy", 32'(abusy), 32'h0);
      chk("t4_y", 32'(ay), 32'h0);
      tick(3);
      chk("t4_y_later", 32'(ay), 32'h0);
      chk("t4_done", 32'(adone), 32'h7);
      chk("t4_err_sticky", 32'(aerr), 32'h1);

      // Reset mid-ack; lane 0 still requesting is re-served after reset.
      ax = 4'b0001;
      tick(3);
      chk("t5_pre_y", 32'(ay), 32'h1);
      RESET = 1'b1;
      tick(1);
      chk("t5_rst_y", 32'(ay), 32'h0);
      chk("t5_rst_busy", 32'(abusy), 32'h0);
      chk("t5_rst_done", 32'(adone), 32'h0);
      chk("t5_rst_err", 32'(aerr), 32'h0);
      RESET = 1'b0;
      tick(2);
      chk("t5_wait_y", 32'(ay), 32'h0);
      tick(1);
      chk("t5_reack_y", 32'(ay), 32'h1);
      ax = 4'b0000;
      tick(1);

      // Zero latency, 2-bit counter: ack next cycle, count wraps 1,2,3,0.
      for (int k = 0; k < 4; k++) begin
         bx = 4'b0001;
         tick(1);
         chk("t6_ack_y", 32'(by), 32'h1);
         chk("t6_busy", 32'(bbusy), 32'h1);
         bx = 4'b0000;
         tick(1);
         chk("t6_rel_y", 32'(by), 32'h0);
         chk("t6_done", 32'(bdone), 32'((k + 1) % 4));
      end
      chk("t6_err", 32'(berr), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
